tea_word_packer: RTL and testbench

Upstream feeder for the tinyenc cipher stage. Accepts a byte stream (valid/ready) and packs every 4 bytes into a 32-bit word. Buffers the words in a small FIFO and presents each one to the encryptor's wdata/req/ack port with a 4-phase handshake. APB-lite registers provide partial-word flush with a pad byte, clear, and status/count readback.

---
 rtl/tea_word_packer_if.sv | 26 ++
 rtl/tea_word_packer.sv | 170 +++++++++++++++++
 tb/tb_tea_word_packer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tea_word_packer_if.sv
// Byte-stream, encryptor wdata/req/ack and APB-lite signals of the tinyenc word packer.
// slave = the packer, master = whatever drives it (feeder, encryptor, APB bridge).
interface tea_word_packer_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        req;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] pwdata;
  logic        pwrite;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;

  modport slave (
    input  byte_valid, byte_data, ack, pwdata, pwrite, paddr, psel, penable,
    output byte_ready, req, wdata, prdata
  );

  modport master (
    output byte_valid, byte_data, ack, pwdata, pwrite, paddr, psel, penable,
    input  byte_ready, req, wdata, prdata
  );
endinterface

// File: rtl/tea_word_packer.sv
// Packs a byte stream into 32-bit words, buffers them in a DEPTH-word FIFO and hands each to tinyenc over a 4-phase req/ack.
// APB-lite: CTRL (flush/clear), PAD, STATUS, WORDS. Define TEA_PACK_MSB_FIRST_EN to place the first byte in [31:24].
module tea_word_packer #(
  parameter int         DEPTH   = 4,
  parameter logic [7:0] PAD_RST = 8'h20
) (
  input  logic pclk,
  input  logic prstb,
  tea_word_packer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

  function automatic logic [4:0] lane_lsb(input logic [1:0] k);
`ifdef TEA_PACK_MSB_FIRST_EN
    return 5'd24 - {k, 3'b000};
`else
    return {k, 3'b000};
`endif
  endfunction

  logic [31:0] r_mem [DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic [1:0]  r_cnt;
  logic [31:0] r_acc;
  logic [7:0]  r_pad;
  logic        r_flush_pending;
  logic        r_ack_m, r_ack_s;
  state_t      r_state;
  logic        r_req;
  logic [31:0] r_wdata;
  logic [15:0] r_words;
  logic        r_avail;
  logic        r_skip_pop;

  logic [AW:0] w_level;
  logic [4:0]  w_level5;
  logic        w_full, w_empty;
  logic        w_byte_ready, w_byte_fire;
  logic        w_apb_wr, w_ctrl_wr, w_clear, w_flush_cmd;
  logic [31:0] w_acc_merged, w_padded, w_push_dat;
  logic [1:0]  w_cnt_after;
  logic        w_push_byte, w_flush_try, w_push_flush, w_push, w_pop;
  logic [31:0] w_prdata;
  logic        w_unused;

  assign w_level  = r_wptr - r_rptr;
  assign w_level5 = 5'(w_level);
  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  // No look-ahead on a concurrent pop: a full FIFO blocks the word-completing byte.
  assign w_byte_ready = ~r_flush_pending & ~(w_full & (r_cnt == 2'd3));
  assign w_byte_fire  = bus.byte_valid & w_byte_ready;

  assign w_apb_wr    = bus.psel & bus.penable & bus.pwrite;
  assign w_ctrl_wr   = w_apb_wr & (bus.paddr[3:2] == 2'd0);
  assign w_clear     = w_ctrl_wr & bus.pwdata[1];
  assign w_flush_cmd = w_ctrl_wr & bus.pwdata[0] & ~bus.pwdata[1];

  // A byte taken on this edge is merged before FLUSH looks at the partial word.
  always_comb begin
    w_acc_merged = r_acc;
    if (w_byte_fire) w_acc_merged[lane_lsb(r_cnt) +: 8] = bus.byte_data;
    w_cnt_after = w_byte_fire ? r_cnt + 2'd1 : r_cnt;
    w_padded = w_acc_merged;
    for (int k = 0; k < 4; k++) begin
      if (2'(k) >= w_cnt_after) w_padded[lane_lsb(2'(k)) +: 8] = r_pad;
    end
  end

  assign w_push_byte  = w_byte_fire & (r_cnt == 2'd3);
  assign w_flush_try  = r_flush_pending | (w_flush_cmd & (w_cnt_after != 2'd0));
  assign w_push_flush = w_flush_try & ~w_full;
  assign w_push       = w_push_byte | w_push_flush;
  assign w_push_dat   = w_push_byte ? w_acc_merged : w_padded;
  assign w_pop        = (r_state == S_REQ) & r_ack_s & ~r_skip_pop;

  always_ff @(posedge pclk) begin
    if (w_push && !w_clear) r_mem[r_wptr[AW-1:0]] <= w_push_dat;
  end

  always_ff @(posedge pclk or negedge prstb) begin
    if (!prstb) begin
      r_wptr          <= '0;
      r_rptr          <= '0;
      r_cnt           <= 2'd0;
      r_acc           <= 32'd0;
      r_pad           <= PAD_RST;
      r_flush_pending <= 1'b0;
      r_ack_m         <= 1'b0;
      r_ack_s         <= 1'b0;
      r_avail         <= 1'b0;
    end else begin
      r_ack_m <= bus.ack;
      r_ack_s <= r_ack_m;
      r_avail <= ~w_empty;
      if (w_byte_fire) r_acc <= w_acc_merged;
      if (w_apb_wr && bus.paddr[3:2] == 2'd1) r_pad <= bus.pwdata[7:0];
      if (w_clear) begin
        r_wptr          <= '0;
        r_rptr          <= '0;
        r_cnt           <= 2'd0;
        r_flush_pending <= 1'b0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        r_cnt           <= w_push_flush ? 2'd0 : w_cnt_after;
        r_flush_pending <= w_flush_try & w_full;
      end
    end
  end

  // r_avail lags the FIFO by a cycle; the live empty check keeps a cleared FIFO from loading.
  always_ff @(posedge pclk or negedge prstb) begin
    if (!prstb) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_wdata    <= 32'd0;
      r_words    <= 16'd0;
      r_skip_pop <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_avail && !w_empty && !w_clear) begin
            r_req   <= 1'b1;
            r_wdata <= r_mem[r_rptr[AW-1:0]];
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (r_ack_s) begin
            r_req      <= 1'b0;
            r_words    <= r_words + 16'd1;
            r_skip_pop <= 1'b0;
            r_state    <= S_DROP;
          end else if (w_clear) begin
            r_skip_pop <= 1'b1;
          end
        end
        S_DROP: begin
          if (!r_ack_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_prdata = 32'd0;
    if (bus.psel && !bus.pwrite) begin
      case (bus.paddr[3:2])
        2'd1:    w_prdata = {24'd0, r_pad};
        2'd2:    w_prdata = {14'd0, r_flush_pending, r_req, 3'd0, w_level5, 6'd0, r_cnt};
        2'd3:    w_prdata = {16'd0, r_words};
        default: w_prdata = 32'd0;
      endcase
    end
  end

  assign w_unused = &{1'b0, bus.paddr[31:4], bus.paddr[1:0], bus.pwdata[31:8]};

  assign bus.byte_ready = w_byte_ready;
  assign bus.req        = r_req;
  assign bus.wdata      = r_wdata;
  assign bus.prdata     = w_prdata;

endmodule

// File: tb/tb_tea_word_packer.sv
// Directed bench for tea_word_packer: expected words queued as bytes/flushes are driven, popped on each req rise.
module tb_tea_word_packer;

  localparam int DEPTH = 4;

  logic pclk;
  logic prstb;
  tea_word_packer_if bus ();

  tea_word_packer #(.DEPTH(DEPTH), .PAD_RST(8'h20)) dut (
    .pclk  (pclk),
    .prstb (prstb),
    .bus   (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q [$];
  logic [7:0]  part  [$];
  logic [7:0]  pad_m = 8'h20;
  bit          ack_en = 1'b0;
  logic [2:0]  ack_pipe = 3'b000;
  logic        prev_req = 1'b0;
  logic [31:0] held = 32'd0;
  logic [31:0] rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic [7:0] b0, b1, b2, b3);
`ifdef TEA_PACK_MSB_FIRST_EN
    return {b0, b1, b2, b3};
`else
    return {b3, b2, b1, b0};
`endif
  endfunction

  task automatic model_byte(input logic [7:0] b);
    part.push_back(b);
    if (part.size() == 4) begin
      exp_q.push_back(pack(part[0], part[1], part[2], part[3]));
      part.delete();
    end
  endtask

  task automatic model_flush();
    if (part.size() > 0) begin
      while (part.size() < 4) part.push_back(pad_m);
      exp_q.push_back(pack(part[0], part[1], part[2], part[3]));
      part.delete();
    end
  endtask

  // Encryptor model: ack follows req three clocks later while enabled.
  always @(negedge pclk) begin
    if (!prstb) ack_pipe = 3'b000;
    else        ack_pipe = {ack_pipe[1:0], bus.req};
    bus.ack = ack_en & ack_pipe[2];
  end

  always @(negedge pclk) begin
    if (prstb) begin
      if (bus.req && !prev_req) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_req observed=%h expected=no word", bus.wdata);
        end
        if (exp_q.size() != 0) check("wdata_at_req", bus.wdata, exp_q.pop_front());
        held = bus.wdata;
      end else if (!bus.req && prev_req) begin
        check("wdata_hold", bus.wdata, held);
        check("ack_at_req_fall", 32'(bus.ack), 32'd1);
      end
    end
    prev_req = bus.req;
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge pclk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (!bus.byte_ready && n < 200) begin
      @(negedge pclk);
      n++;
    end
    check("byte_accept", 32'(n < 200), 32'd1);
    if (n < 200) model_byte(b);
    @(posedge pclk);
    #1 bus.byte_valid = 1'b0;
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge pclk);
    bus.psel = 1'b1; bus.pwrite = 1'b1; bus.paddr = 32'(a); bus.pwdata = d; bus.penable = 1'b0;
    @(negedge pclk);
    bus.penable = 1'b1;
    @(negedge pclk);
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge pclk);
    bus.psel = 1'b1; bus.pwrite = 1'b0; bus.paddr = 32'(a); bus.penable = 1'b0;
    @(negedge pclk);
    bus.penable = 1'b1;
    d = bus.prdata;
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.req) && n < 3000) begin
      @(negedge pclk);
      n++;
    end
    check("drain_in_time", 32'(n < 3000), 32'd1);
    repeat (6) @(negedge pclk);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!bus.req && n < 200) begin
      @(negedge pclk);
      n++;
    end
    check("req_in_time", 32'(bus.req), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge pclk);
    prstb = 1'b0;
    exp_q.delete();
    part.delete();
    pad_m = 8'h20;
    repeat (2) @(negedge pclk);
    prstb = 1'b1;
  endtask

  initial begin
    prstb = 1'b0;
    bus.byte_valid = 1'b0; bus.byte_data = 8'h00;
    bus.pwdata = 32'd0; bus.pwrite = 1'b0; bus.paddr = 32'd0;
    bus.psel = 1'b0; bus.penable = 1'b0;
    @(negedge pclk);
    check("rst_req", 32'(bus.req), 32'd0);
    check("rst_wdata", bus.wdata, 32'd0);
    check("rst_byte_ready", 32'(bus.byte_ready), 32'd1);
    check("rst_prdata", bus.prdata, 32'd0);
    @(negedge pclk);
    prstb = 1'b1;
    apb_read(4'h8, rd); check("rst_status", rd, 32'd0);
    apb_read(4'hC, rd); check("rst_words", rd, 32'd0);
    apb_read(4'h4, rd); check("rst_pad", rd, 32'h20);
    apb_read(4'h0, rd); check("ctrl_reads_0", rd, 32'd0);

    // Single word, req latency two edges after the 4th byte
    ack_en = 1'b1;
    send_byte(8'h41); send_byte(8'h42); send_byte(8'h43); send_byte(8'h44);
    @(posedge pclk); #1 check("lat_n1_req", 32'(bus.req), 32'd0);
    @(posedge pclk); #1 check("lat_n2_req", 32'(bus.req), 32'd1);
    wait_drain();
    apb_read(4'hC, rd); check("t1_words", rd, 32'd1);

    // Partial word flushed with pad
    apb_write(4'h4, 32'h5A); apb_read(4'h4, rd); check("pad_rw", rd, 32'h5A);
    apb_write(4'h4, 32'h20); pad_m = 8'h20;
    send_byte(8'h61); send_byte(8'h62);
    apb_write(4'h0, 32'h1); model_flush();
    apb_read(4'h8, rd); check("t2_cnt", 32'(rd[1:0]), 32'd0);
    wait_drain();

    // Back-pressure with ack held low
    do_reset();
    ack_en = 1'b0;
    for (int i = 0; i < 4*DEPTH+3; i++) send_byte(8'(i + 1));
    @(negedge pclk);
    bus.byte_valid = 1'b1; bus.byte_data = 8'h14;
    repeat (4) @(negedge pclk);
    check("t3_ready_blocked", 32'(bus.byte_ready), 32'd0);
    apb_read(4'h8, rd); check("t3_status", rd, 32'h0001_0403);
    bus.byte_valid = 1'b0;

    // Release ack: four words drain in order, then the 20th byte goes in
    ack_en = 1'b1;
    wait_drain();
    apb_read(4'hC, rd); check("t4_words", rd, 32'd4);
    send_byte(8'h14);
    wait_drain();
    apb_read(4'hC, rd); check("t4_words_after", rd, 32'd5);

    // Reset while req is high
    apb_write(4'h4, 32'h33); pad_m = 8'h33;
    ack_en = 1'b0;
    send_byte(8'h71); send_byte(8'h72); send_byte(8'h73); send_byte(8'h74);
    wait_req();
    @(negedge pclk);
    prstb = 1'b0;
    #1 check("t5_req_async", 32'(bus.req), 32'd0);
    exp_q.delete(); part.delete(); pad_m = 8'h20;
    repeat (2) @(negedge pclk);
    prstb = 1'b1;
    ack_en = 1'b1;
    apb_read(4'h8, rd); check("t5_status", rd, 32'd0);
    apb_read(4'hC, rd); check("t5_words", rd, 32'd0);
    apb_read(4'h4, rd); check("t5_pad", rd, 32'h20);

    // 4th byte and FLUSH on the same edge: no pad word
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    @(negedge pclk);
    bus.psel = 1'b1; bus.pwrite = 1'b1; bus.paddr = 32'h0; bus.pwdata = 32'h1; bus.penable = 1'b0;
    @(negedge pclk);
    bus.penable = 1'b1; bus.byte_valid = 1'b1; bus.byte_data = 8'hA4;
    check("t6_ready_at_flush", 32'(bus.byte_ready), 32'd1);
    model_byte(8'hA4); model_flush();
    @(negedge pclk);
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.byte_valid = 1'b0;
    wait_drain();
    apb_read(4'hC, rd); check("t6_words", rd, 32'd1);
    send_byte(8'hB1); send_byte(8'hB2);
    apb_read(4'h8, rd); check("t6_cnt2", rd, 32'h2);
    apb_write(4'h0, 32'h2); part.delete();
    apb_read(4'h8, rd); check("t6_clear_status", rd, 32'd0);
    send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3); send_byte(8'hC4);
    wait_drain();
    apb_read(4'hC, rd); check("t6_words2", rd, 32'd2);

    // FLUSH with a full FIFO stays pending until space frees
    ack_en = 1'b0;
    for (int i = 0; i < 4*DEPTH; i++) send_byte(8'(8'h80 + i));
    send_byte(8'hD1); send_byte(8'hD2);
    apb_write(4'h0, 32'h1); model_flush();
    apb_read(4'h8, rd); check("t7_pending_status", rd, 32'h0003_0402);
    check("t7_ready_pending", 32'(bus.byte_ready), 32'd0);
    ack_en = 1'b1;
    wait_drain();
    apb_read(4'h8, rd); check("t7_status_after", rd, 32'd0);
    apb_read(4'hC, rd); check("t7_words", rd, 32'd7);

    // CLEAR+FLUSH during an in-flight handshake: clear wins, no pop
    ack_en = 1'b0;
    for (int i = 0; i < 9; i++) send_byte(8'(8'hE0 + i));
    wait_req();
    apb_write(4'h0, 32'h3); exp_q.delete(); part.delete();
    apb_read(4'h8, rd); check("t8_clear_status", rd, 32'h0001_0000);
    ack_en = 1'b1;
    wait_drain();
    repeat (20) @(negedge pclk);
    apb_read(4'h8, rd); check("t8_status_after", rd, 32'd0);
    apb_read(4'hC, rd); check("t8_words", rd, 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
